ramb16_s18_rd_stream: RTL and testbench

// - Downstream drain stage for the 1Kx18 port B of the 16Kx1/1Kx18 dual-port block RAM.
// - On START, reads LEN consecutive 18-bit words from BASE (10-bit address, wraps 1023->0).
// - Absorbs the RAM's 1-cycle read latency and checks the per-byte parity bits (DOPB).
// - Presents the words as a valid/ready stream with a last-word marker.

---
 rtl/ramb16_s18_rd_stream_if.sv | 31 +++
 rtl/ramb16_s18_rd_stream.sv | 178 +++++++++++++++++
 tb/tb_ramb16_s18_rd_stream.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramb16_s18_rd_stream_if.sv
// Bus bundles for the read-stream drain stage: RAM port B and output stream.
// Latency: none; these are wiring only.
// Backpressure: the stream slave throttles the master through DREADY.

interface ramb16_s18_rd_stream_ram_if;
    logic        ENB;
    logic        WEB;
    logic        SSRB;
    logic [9:0]  ADDRB;
    logic [15:0] DOB;
    logic [1:0]  DOPB;

    modport master (output ENB, output WEB, output SSRB, output ADDRB,
                    input  DOB, input  DOPB);
    modport slave  (input  ENB, input  WEB, input  SSRB, input  ADDRB,
                    output DOB, output DOPB);
endinterface

interface ramb16_s18_rd_stream_if;
    logic [15:0] DOUT;
    logic [1:0]  DOUTP;
    logic        DVALID;
    logic        DREADY;
    logic        DLAST;
    logic        DPERR;

    modport master (output DOUT, output DOUTP, output DVALID, output DLAST,
                    output DPERR, input DREADY);
    modport slave  (input  DOUT, input  DOUTP, input  DVALID, input  DLAST,
                    input  DPERR, output DREADY);
endinterface

// File: rtl/ramb16_s18_rd_stream.sv
// Streams LEN words from a 1Kx18 block-RAM port B, checking per-byte parity.
// Latency: START to first DVALID is 3 cycles; 1 word/cycle sustained with FIFO_DEPTH>=2.
// Backpressure: reads are only issued when the skid FIFO can absorb them; DREADY=0 stalls.

module ramb16_s18_rd_stream #(
    parameter bit PARITY_ODD = 1'b0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        SSR_N,
    input  logic        START,
    input  logic [9:0]  BASE,
    input  logic [10:0] LEN,
    ramb16_s18_rd_stream_ram_if.master ram,
    ramb16_s18_rd_stream_if.master     strm,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  ERR_CNT
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic        perr;
        logic        last;
        logic [1:0]  par;
        logic [15:0] dat;
    } entry_t;

    state_t          state_q, state_d;
    logic [9:0]      addr_q, addr_d;
    logic [10:0]     rem_q, rem_d;
    logic            infl_q, infl_d;
    logic            infl_last_q, infl_last_d;
    entry_t          fifo_q [FIFO_DEPTH];
    entry_t          fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            done_q, done_d;
    logic [7:0]      err_q, err_d;

    logic            issue;
    logic            pop;
    logic            push;
    logic            dvalid;
    entry_t          head;
    entry_t          push_ent;
    logic [OW:0]     fill_lhs;
    logic [OW:0]     fill_rhs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign dvalid   = (occ_q != '0);
    assign pop      = dvalid & strm.DREADY;
    assign push     = infl_q;
    assign head     = fifo_q[rd_ptr_q];
    // Words already stored plus the one on the RAM output, minus the one leaving now.
    assign fill_lhs = {1'b0, occ_q} + (OW+1)'(infl_q);
    assign fill_rhs = (OW+1)'(FIFO_DEPTH) + (OW+1)'(pop);

    // State and control registers; reset discards the FIFO and any in-flight read.
    always_ff @(posedge CLK) begin
        if (!SSR_N) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // FIFO storage; contents are qualified by occupancy so need no reset.
    always_ff @(posedge CLK) begin
        fifo_q <= fifo_d;
    end

    // Next-state: burst start, end of issuing, and completion on the last transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START && (LEN != 11'd0)) state_d = ISSUE;
            ISSUE:   if (issue && (rem_q == 11'd1)) state_d = DRAIN;
            DRAIN:   if (pop && head.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: issue a read only while the FIFO is guaranteed room for it.
    always_comb begin
        issue = 1'b0;
        BUSY  = (state_q != IDLE);
        if ((state_q == ISSUE) && (fill_lhs < fill_rhs)) begin
            issue = 1'b1;
        end
    end

    // Datapath: address/count stepping, parity check on push, FIFO pointers, error count.
    always_comb begin
        addr_d      = addr_q;
        rem_d       = rem_q;
        infl_d      = issue;
        infl_last_d = issue && (rem_q == 11'd1);
        done_d      = 1'b0;
        if ((state_q == IDLE) && START) begin
            if (LEN != 11'd0) begin
                addr_d = BASE;
                rem_d  = LEN;
            end else begin
                done_d = 1'b1;
            end
        end else if (issue) begin
            addr_d = addr_q + 10'd1;
            rem_d  = rem_q - 11'd1;
        end
        if ((state_q == DRAIN) && pop && head.last) begin
            done_d = 1'b1;
        end

        push_ent.dat  = ram.DOB;
        push_ent.par  = ram.DOPB;
        push_ent.last = infl_last_q;
        push_ent.perr = (ram.DOPB[0] != ((^ram.DOB[7:0])  ^ PARITY_ODD)) |
                        (ram.DOPB[1] != ((^ram.DOB[15:8]) ^ PARITY_ODD));

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_ent;
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        err_d = err_q;
        if (pop && head.perr && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    assign ram.ENB     = issue;
    assign ram.ADDRB   = addr_q;
    assign ram.WEB     = 1'b0;
    assign ram.SSRB    = 1'b0;
    assign strm.DVALID = dvalid;
    assign strm.DOUT   = head.dat;
    assign strm.DOUTP  = head.par;
    assign strm.DLAST  = dvalid & head.last;
    assign strm.DPERR  = dvalid & head.perr;
    assign DONE        = done_q;
    assign ERR_CNT     = err_q;

endmodule

// File: tb/tb_ramb16_s18_rd_stream.sv
// Bench for the block-RAM read stream: RAM model, random ready, queue-based reference.
// Latency: expects first DVALID 3 cycles after START and DONE 1 cycle after DLAST.
// Backpressure: drives DREADY steady, patterned, random and held low.

module tb_ramb16_s18_rd_stream;

    localparam bit PODD  = 1'b0;
    localparam int DEPTH = 2;

    logic        clk;
    logic        ssr_n;
    logic        start;
    logic [9:0]  base;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;

    ramb16_s18_rd_stream_ram_if ram_if ();
    ramb16_s18_rd_stream_if     st_if ();

    ramb16_s18_rd_stream #(.PARITY_ODD(PODD), .FIFO_DEPTH(DEPTH)) dut (
        .CLK     (clk),
        .SSR_N   (ssr_n),
        .START   (start),
        .BASE    (base),
        .LEN     (len),
        .ram     (ram_if),
        .strm    (st_if),
        .BUSY    (busy),
        .DONE    (done),
        .ERR_CNT (err_cnt)
    );

    logic [17:0] mem [1024];
    int          cyc;
    int          chk_total;
    int          chk_pass;
    logic [19:0] expq [$];
    int          issued;
    int          xfers;
    int          first_cyc;
    int          err_model;
    int          rdy_mode;
    bit          exp_done;
    bit          stall_q;
    bit          mon_en;
    logic [19:0] held;
    logic [19:0] cur;
    logic [19:0] e;
    logic [9:0]  exp_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data appears the cycle after ENB.
    always @(posedge clk) begin
        if (ram_if.ENB) {ram_if.DOPB, ram_if.DOB} <= mem[ram_if.ADDRB];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_total++;
        if (got === exp) chk_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic parity_bit(input logic [7:0] b);
        return logic'($countones(b) % 2) ^ PODD;
    endfunction

    function automatic logic [17:0] good_word(input logic [15:0] d);
        return {parity_bit(d[15:8]), parity_bit(d[7:0]), d};
    endfunction

    function automatic logic [17:0] bad_word(input logic [15:0] d);
        return {parity_bit(d[15:8]), ~parity_bit(d[7:0]), d};
    endfunction

    // Expected stream entry {last, perr, parity, data} derived from memory contents.
    function automatic logic [19:0] exp_word(input int a, input bit last);
        logic [17:0] w;
        bit pe;
        w  = mem[a];
        pe = (w[16] != parity_bit(w[7:0])) || (w[17] != parity_bit(w[15:8]));
        return {last, pe, w[17:16], w[15:0]};
    endfunction

    // DREADY generator.
    initial begin
        st_if.DREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       st_if.DREADY = 1'b1;
                1:       st_if.DREADY = ((cyc % 3) == 0);
                2:       st_if.DREADY = $urandom_range(1, 0) == 1;
                default: st_if.DREADY = 1'b0;
            endcase
        end
    end

    // Monitor: addresses, outstanding reads, word order/content, hold-while-stalled, DONE.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {st_if.DLAST, st_if.DPERR, st_if.DOUTP, st_if.DOUT};
                if (exp_done) begin
                    chk("done_after_last", 32'(done), 32'd1);
                    exp_done = 1'b0;
                end
                if (stall_q) begin
                    chk("hold_valid", 32'(st_if.DVALID), 32'd1);
                    chk("hold_word", 32'(cur), 32'(held));
                end
                if (st_if.DVALID && st_if.DREADY) begin
                    xfers++;
                    if (first_cyc < 0) first_cyc = cyc;
                    if (expq.size() == 0) begin
                        chk("xfer_extra", 32'd1, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("word", 32'(cur), 32'(e));
                        if (e[18] && err_model < 255) err_model++;
                        if (e[19]) exp_done = 1'b1;
                    end
                end
                if (ram_if.ENB) begin
                    issued++;
                    chk("addrb", 32'(ram_if.ADDRB), 32'(exp_addr));
                    exp_addr = exp_addr + 10'd1;
                    chk("outstanding", 32'(issued - xfers <= DEPTH), 32'd1);
                end
                stall_q = st_if.DVALID && !st_if.DREADY;
                held    = cur;
            end
        end
    end

    task automatic pulse_start(input int b, input int l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = 10'(b);
        len   = 11'(l);
    endtask

    task automatic run_burst(input int b, input int l, input int mode,
                             input bit chk_lat, input bit inject);
        int start_c;
        int n;
        rdy_mode  = inject ? 3 : mode;
        issued    = 0;
        xfers     = 0;
        first_cyc = -1;
        for (int i = 0; i < l; i++) expq.push_back(exp_word((b + i) % 1024, i == l - 1));
        exp_addr = 10'(b);
        pulse_start(b, l);
        start_c = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (inject) begin
            repeat (4) @(posedge clk);
            #1;
            chk("busy_stalled", 32'(busy), 32'd1);
            start = 1'b1;
            base  = 10'd50;
            len   = 11'd9;
            @(posedge clk);
            #1;
            start    = 1'b0;
            rdy_mode = mode;
        end
        n = 0;
        while (!done && n < l * 8 + 40) begin
            @(negedge clk);
            n++;
        end
        chk("burst_done", 32'(done), 32'd1);
        if (chk_lat) begin
            chk("start_to_dvalid", 32'(first_cyc - start_c), 32'd3);
            chk("contiguous", 32'(cyc - first_cyc), 32'(l));
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        chk("err_cnt", 32'(err_cnt), 32'(err_model));
    endtask

    initial begin
        int n;
        ssr_n     = 1'b0;
        start     = 1'b0;
        base      = '0;
        len       = '0;
        rdy_mode  = 0;
        mon_en    = 1'b0;
        err_model = 0;
        exp_done  = 1'b0;
        stall_q   = 1'b0;
        issued    = 0;
        xfers     = 0;
        first_cyc = -1;
        chk_total = 0;
        chk_pass  = 0;
        for (int i = 0; i < 1024; i++) mem[i] = good_word(16'($urandom));

        repeat (3) @(posedge clk);
        #1;
        ssr_n = 1'b1;
        @(negedge clk);
        chk("rst_enb", 32'(ram_if.ENB), 32'd0);
        chk("rst_addrb", 32'(ram_if.ADDRB), 32'd0);
        chk("rst_dvalid", 32'(st_if.DVALID), 32'd0);
        chk("rst_dlast", 32'(st_if.DLAST), 32'd0);
        chk("rst_dperr", 32'(st_if.DPERR), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("web_tied", 32'({ram_if.WEB, ram_if.SSRB}), 32'd0);
        mon_en = 1'b1;

        // Basic burst with latency and back-to-back transfers.
        for (int i = 5; i <= 8; i++) mem[i] = good_word(16'($urandom));
        run_burst(5, 4, 0, 1'b1, 1'b0);
        // Address wrap.
        run_burst(1022, 3, 0, 1'b0, 1'b0);
        // Patterned stalls.
        run_burst(20, 4, 1, 1'b0, 1'b0);
        run_burst(30, 12, 1, 1'b0, 1'b0);

        // Parity error detection and counter saturation.
        mem[0] = {2'b00, 16'h0001};
        run_burst(0, 1, 0, 1'b0, 1'b0);
        chk("err_cnt_one", 32'(err_cnt), 32'd1);
        for (int i = 100; i < 400; i++) mem[i] = bad_word(16'($urandom));
        run_burst(100, 300, 0, 1'b0, 1'b0);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        // START while busy is ignored.
        run_burst(200, 6, 0, 1'b0, 1'b1);

        // LEN=0 START: DONE next cycle, no reads.
        issued = 0;
        pulse_start(7, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("len0_no_enb", 32'(issued), 32'd0);

        // Reset mid-burst.
        for (int i = 500; i < 508; i++) mem[i] = good_word(16'($urandom));
        rdy_mode = 0;
        issued   = 0;
        xfers    = 0;
        for (int i = 0; i < 8; i++) expq.push_back(exp_word(500 + i, i == 7));
        exp_addr = 10'd500;
        pulse_start(500, 8);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (xfers < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mid_burst_reached", 32'(xfers >= 2), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        ssr_n  = 1'b0;
        @(posedge clk);
        #1;
        ssr_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_dvalid", 32'(st_if.DVALID), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_enb", 32'(ram_if.ENB), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        expq.delete();
        err_model = 0;
        stall_q   = 1'b0;
        exp_done  = 1'b0;
        mon_en    = 1'b1;
        run_burst(600, 5, 0, 1'b1, 1'b0);

        // Randomized bursts with occasional bad parity.
        for (int t = 0; t < 10; t++) begin
            int b;
            int l;
            b = $urandom_range(1023, 0);
            l = $urandom_range(40, 1);
            for (int i = 0; i < l; i++) begin
                if ($urandom_range(3, 0) == 0) mem[(b + i) % 1024] = bad_word(16'($urandom));
                else mem[(b + i) % 1024] = good_word(16'($urandom));
            end
            run_burst(b, l, $urandom_range(2, 0), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
